// File: rtl/ysyx_23060124_if_id_queue.sv
// ysyx_23060124_if_id_queue: IFU->IDU fetch FIFO with valid/ready handshake and one-cycle flush
module ysyx_23060124_if_id_queue #(
  parameter int DEPTH = 2,
  parameter int ISA_WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [ISA_WIDTH-1:0]       in_pc,
  input  logic [ISA_WIDTH-1:0]       in_ins,
  input  logic                       in_err,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [ISA_WIDTH-1:0]       out_pc,
  output logic [ISA_WIDTH-1:0]       out_ins,
  output logic                       out_err,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [ISA_WIDTH-1:0] pc_q [DEPTH];
  logic [ISA_WIDTH-1:0] ins_q [DEPTH];
  logic [DEPTH-1:0] err_q;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic push, pop;
  always_comb begin
    in_ready  = count_q != CW'(DEPTH);
    out_valid = count_q != '0;
    push      = in_valid & in_ready;
    pop       = out_valid & out_ready;
    wr_ptr_d  = flush ? '0 : wr_ptr_q + AW'(push);
    rd_ptr_d  = flush ? '0 : rd_ptr_q + AW'(pop);
    count_d   = flush ? '0 : count_q + CW'(push) - CW'(pop);
    out_pc    = pc_q[rd_ptr_q];
    out_ins   = ins_q[rd_ptr_q];
    out_err   = err_q[rd_ptr_q];
    count     = count_q;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      err_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_q[i]  <= '0;
        ins_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push && !flush) begin
        pc_q[wr_ptr_q]  <= in_pc;
        ins_q[wr_ptr_q] <= in_ins;
        err_q[wr_ptr_q] <= in_err;
      end
    end
  end
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst) !(in_valid && in_ready && count_q == CW'(DEPTH)));
  a_no_underflow: assert property (@(posedge clk) disable iff (!rst) !(out_valid && out_ready && count_q == '0));
endmodule

// File: tb/tb_ysyx_23060124_if_id_queue.sv
// tb_ysyx_23060124_if_id_queue: directed table-driven bench for the IF/ID queue
module tb_ysyx_23060124_if_id_queue;
  logic clk = 0, rst = 0, flush = 0, in_valid = 0, in_err = 0, out_ready = 0;
  logic [31:0] in_pc = 0, in_ins = 0;
  logic in_ready, out_valid, out_err;
  logic [31:0] out_pc, out_ins;
  logic [1:0] count;
  int total = 0, bad = 0;
  ysyx_23060124_if_id_queue #(.DEPTH(2), .ISA_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_ins(in_ins), .in_err(in_err), .out_valid(out_valid),
    .out_ready(out_ready), .out_pc(out_pc), .out_ins(out_ins), .out_err(out_err),
    .count(count)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic fl, iv; logic [31:0] pc, ins; logic er, ordy;
    logic ev, eir; logic [1:0] ecnt; logic cd; logic [31:0] epc, eins; logic eer;
  } vec_t;
  vec_t v[$];
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask
  function automatic vec_t mk(logic fl, logic iv, logic [31:0] pc, logic [31:0] ins, logic er, logic ordy,
                              logic ev, logic eir, logic [1:0] ecnt, logic cd, logic [31:0] epc, logic [31:0] eins, logic eer);
    vec_t r;
    r.fl = fl; r.iv = iv; r.pc = pc; r.ins = ins; r.er = er; r.ordy = ordy;
    r.ev = ev; r.eir = eir; r.ecnt = ecnt; r.cd = cd; r.epc = epc; r.eins = eins; r.eer = eer;
    return r;
  endfunction
  int k, j, cyc;
  logic take_in, take_out;
  logic [31:0] got_pc;
  initial begin
    v.push_back(mk(0,1,32'h80000000,32'h00000413,0,1, 1,1,1,1,32'h80000000,32'h00000413,0));
    v.push_back(mk(0,0,0,0,0,1,                      0,1,0,0,0,0,0));
    v.push_back(mk(0,1,32'h80000000,32'h11,0,0,      1,1,1,1,32'h80000000,32'h11,0));
    v.push_back(mk(0,1,32'h80000004,32'h22,0,0,      1,0,2,1,32'h80000000,32'h11,0));
    v.push_back(mk(0,1,32'h80000008,32'h33,0,0,      1,0,2,1,32'h80000000,32'h11,0));
    v.push_back(mk(0,1,32'h80000008,32'h33,0,1,      1,1,1,1,32'h80000004,32'h22,0));
    v.push_back(mk(0,0,0,0,0,1,                      0,1,0,0,0,0,0));
    v.push_back(mk(0,1,32'h800000a0,32'h44,0,0,      1,1,1,1,32'h800000a0,32'h44,0));
    v.push_back(mk(0,1,32'h800000a4,32'h55,0,0,      1,0,2,1,32'h800000a0,32'h44,0));
    v.push_back(mk(1,1,32'h800000a8,32'h66,0,1,      0,1,0,0,0,0,0));
    v.push_back(mk(0,0,0,0,0,0,                      0,1,0,0,0,0,0));
    v.push_back(mk(0,1,32'h800000b0,32'h77,0,0,      1,1,1,1,32'h800000b0,32'h77,0));
    v.push_back(mk(0,0,0,0,0,1,                      0,1,0,0,0,0,0));
    v.push_back(mk(0,1,32'h30000000,32'h88,1,0,      1,1,1,1,32'h30000000,32'h88,1));
    v.push_back(mk(0,1,32'h30000004,32'h99,0,0,      1,0,2,1,32'h30000000,32'h88,1));
    v.push_back(mk(0,0,0,0,0,1,                      1,1,1,1,32'h30000004,32'h99,0));
    v.push_back(mk(0,0,0,0,0,1,                      0,1,0,0,0,0,0));
    #2;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_count", 32'(count), 0);
    chk("rst_out_pc", out_pc, 0);
    chk("rst_out_ins", out_ins, 0);
    chk("rst_out_err", 32'(out_err), 0);
    #10 rst = 1;
    @(posedge clk); #1;
    for (int i = 0; i < v.size(); i++) begin
      flush = v[i].fl; in_valid = v[i].iv; in_pc = v[i].pc; in_ins = v[i].ins;
      in_err = v[i].er; out_ready = v[i].ordy;
      @(posedge clk); #1;
      chk($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'(v[i].ev));
      chk($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'(v[i].eir));
      chk($sformatf("v%0d_count", i), 32'(count), 32'(v[i].ecnt));
      if (v[i].cd) begin
        chk($sformatf("v%0d_out_pc", i), out_pc, v[i].epc);
        chk($sformatf("v%0d_out_ins", i), out_ins, v[i].eins);
        chk($sformatf("v%0d_out_err", i), 32'(out_err), 32'(v[i].eer));
      end
    end
    flush = 0; in_err = 0; in_ins = 0;
    k = 0; j = 0; cyc = 0;
    while ((k < 10 || j < 10) && cyc < 100) begin
      in_valid = k < 10;
      in_pc = 32'h80000000 + 32'(4 * k);
      in_ins = 32'(k);
      out_ready = cyc[0];
      #3;
      take_in = in_valid & in_ready;
      take_out = out_valid & out_ready;
      got_pc = out_pc;
      @(posedge clk); #1;
      if (take_in) k++;
      if (take_out) begin
        chk($sformatf("wrap_pc%0d", j), got_pc, 32'h80000000 + 32'(4 * j));
        j++;
      end
      cyc++;
    end
    chk("wrap_popped", 32'(j), 10);
    chk("wrap_pushed", 32'(k), 10);
    in_valid = 0; out_ready = 0;
    @(posedge clk); #1;
    chk("wrap_count_end", 32'(count), 0);
    in_valid = 1; in_pc = 32'h40000000; in_err = 1;
    @(posedge clk); #1;
    in_pc = 32'h40000004; in_err = 0;
    @(posedge clk); #1;
    in_valid = 0;
    chk("pre_rst_count", 32'(count), 2);
    #2 rst = 0;
    #1;
    chk("async_rst_out_valid", 32'(out_valid), 0);
    chk("async_rst_count", 32'(count), 0);
    chk("async_rst_in_ready", 32'(in_ready), 1);
    chk("async_rst_out_pc", out_pc, 0);
    #2 rst = 1;
    @(posedge clk); #1;
    chk("post_rst_out_valid", 32'(out_valid), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
